// File: rtl/mc_pkg.sv
// Shared constants and types for the Monte-Carlo frame datapath.
// Frame geometry, sample width, result timeout and transmitter state encoding.
package mc_pkg;
    localparam int MC_N        = 256;
    localparam int MC_DW       = 16;
    localparam int MC_WAIT_MAX = 4096;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SEND     = 2'd1,
        WAIT_RES = 2'd2
    } mc_tx_state_t;
endpackage

// File: rtl/mc_frame_buf.sv
// Three-lane frame store: one write port, one read port with registered data.
// Storage is not reset; only the read registers clear on reset or on request.
module mc_frame_buf #(
    parameter int N  = 256,
    parameter int DW = 16,
    localparam int AW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en_i,
    input  logic [AW-1:0] wr_addr_i,
    input  logic [DW-1:0] wr_x_i,
    input  logic [DW-1:0] wr_dr_i,
    input  logic [DW-1:0] wr_di_i,
    input  logic          rd_en_i,
    input  logic          rd_clr_i,
    input  logic [AW-1:0] rd_addr_i,
    output logic [DW-1:0] rd_x_o,
    output logic [DW-1:0] rd_dr_o,
    output logic [DW-1:0] rd_di_o
);
    logic [DW-1:0] mem_x  [N];
    logic [DW-1:0] mem_dr [N];
    logic [DW-1:0] mem_di [N];
    logic [DW-1:0] rd_x_q, rd_dr_q, rd_di_q;

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_x[wr_addr_i]  <= wr_x_i;
            mem_dr[wr_addr_i] <= wr_dr_i;
            mem_di[wr_addr_i] <= wr_di_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_x_q  <= '0;
            rd_dr_q <= '0;
            rd_di_q <= '0;
        end else if (rd_clr_i) begin
            rd_x_q  <= '0;
            rd_dr_q <= '0;
            rd_di_q <= '0;
        end else if (rd_en_i) begin
            rd_x_q  <= mem_x[rd_addr_i];
            rd_dr_q <= mem_dr[rd_addr_i];
            rd_di_q <= mem_di[rd_addr_i];
        end
    end

    assign rd_x_o  = rd_x_q;
    assign rd_dr_o = rd_dr_q;
    assign rd_di_o = rd_di_q;
endmodule

// File: rtl/mc_frame_tx.sv
// Streams one buffered frame into MC as N gapless beats, then counts N returns or times out.
// Beat 0 is presented the cycle after start; host writes outside IDLE are dropped and flagged.
module mc_frame_tx
    import mc_pkg::*;
#(
    parameter int N        = MC_N,
    parameter int DW       = MC_DW,
    parameter int WAIT_MAX = MC_WAIT_MAX,
    localparam int AW = $clog2(N),
    localparam int CW = AW + 1,
    localparam int WW = $clog2(WAIT_MAX + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_x,
    input  logic [DW-1:0] wr_dr,
    input  logic [DW-1:0] wr_di,
    input  logic          start,
    output logic          wr_reject,
    output logic          busy,
    output logic          in_valid,
    output logic [DW-1:0] x_real,
    output logic [DW-1:0] delta_real,
    output logic [DW-1:0] delta_img,
    input  logic          out_valid,
    output logic          frame_done,
    output logic          frame_err
);
    mc_tx_state_t  state_q, state_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d, rx_next;
    logic [WW-1:0] wait_cnt_q, wait_cnt_d;
    logic          in_valid_q, in_valid_d;
    logic          frame_done_q, frame_done_d;
    logic          frame_err_q, frame_err_d;
    logic          wr_reject_q, wr_reject_d;
    logic          wr_ok, rd_en, rd_clr;
    logic [AW-1:0] rd_addr;

    always_comb begin
        state_d      = state_q;
        tx_cnt_d     = tx_cnt_q;
        rx_cnt_d     = rx_cnt_q;
        wait_cnt_d   = wait_cnt_q;
        in_valid_d   = in_valid_q;
        frame_done_d = 1'b0;
        frame_err_d  = 1'b0;
        rd_en        = 1'b0;
        rd_clr       = 1'b0;
        rd_addr      = '0;
        // A write coinciding with start is dropped so the frame sent is a stable snapshot.
        wr_ok        = wr_en && (state_q == IDLE) && !start;
        wr_reject_d  = wr_en && !wr_ok;
        rx_next      = (rx_cnt_q == CW'(N)) ? rx_cnt_q : rx_cnt_q + CW'(out_valid);

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = SEND;
                    in_valid_d = 1'b1;
                    tx_cnt_d   = '0;
                    rx_cnt_d   = '0;
                    rd_en      = 1'b1;
                end
            end
            SEND: begin
                rx_cnt_d = rx_next;
                if (tx_cnt_q == CW'(N - 1)) begin
                    state_d    = WAIT_RES;
                    in_valid_d = 1'b0;
                    rd_clr     = 1'b1;
                    wait_cnt_d = '0;
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                    rd_en    = 1'b1;
                    rd_addr  = tx_cnt_d[AW-1:0];
                end
            end
            WAIT_RES: begin
                rx_cnt_d   = rx_next;
                wait_cnt_d = wait_cnt_q + 1'b1;
                if (rx_next == CW'(N)) begin
                    frame_done_d = 1'b1;
                    state_d      = IDLE;
                end else if (wait_cnt_d == WW'(WAIT_MAX)) begin
                    frame_err_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            tx_cnt_q     <= '0;
            rx_cnt_q     <= '0;
            wait_cnt_q   <= '0;
            in_valid_q   <= 1'b0;
            frame_done_q <= 1'b0;
            frame_err_q  <= 1'b0;
            wr_reject_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            tx_cnt_q     <= tx_cnt_d;
            rx_cnt_q     <= rx_cnt_d;
            wait_cnt_q   <= wait_cnt_d;
            in_valid_q   <= in_valid_d;
            frame_done_q <= frame_done_d;
            frame_err_q  <= frame_err_d;
            wr_reject_q  <= wr_reject_d;
        end
    end

    mc_frame_buf #(.N(N), .DW(DW)) u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en_i   (wr_ok),
        .wr_addr_i (wr_addr),
        .wr_x_i    (wr_x),
        .wr_dr_i   (wr_dr),
        .wr_di_i   (wr_di),
        .rd_en_i   (rd_en),
        .rd_clr_i  (rd_clr),
        .rd_addr_i (rd_addr),
        .rd_x_o    (x_real),
        .rd_dr_o   (delta_real),
        .rd_di_o   (delta_img)
    );

    assign busy       = (state_q != IDLE);
    assign in_valid   = in_valid_q;
    assign frame_done = frame_done_q;
    assign frame_err  = frame_err_q;
    assign wr_reject  = wr_reject_q;
endmodule

// File: tb/tb_mc_frame_tx.sv
// Bench for mc_frame_tx: random frames and return timing checked against a frame-level model.
module tb_mc_frame_tx;
    localparam int N        = 256;
    localparam int DW       = 16;
    localparam int WAIT_MAX = 4096;

    logic          clk, rst_n;
    logic          wr_en, start, out_valid;
    logic [7:0]    wr_addr;
    logic [DW-1:0] wr_x, wr_dr, wr_di;
    logic          wr_reject, busy, in_valid, frame_done, frame_err;
    logic [DW-1:0] x_real, delta_real, delta_img;

    mc_frame_tx #(.N(N), .DW(DW), .WAIT_MAX(WAIT_MAX)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_x       (wr_x),
        .wr_dr      (wr_dr),
        .wr_di      (wr_di),
        .start      (start),
        .wr_reject  (wr_reject),
        .busy       (busy),
        .in_valid   (in_valid),
        .x_real     (x_real),
        .delta_real (delta_real),
        .delta_img  (delta_img),
        .out_valid  (out_valid),
        .frame_done (frame_done),
        .frame_err  (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Frame contents the host has successfully written.
    logic [DW-1:0] mx [N];
    logic [DW-1:0] mdr[N];
    logic [DW-1:0] mdi[N];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int t       = -1;

    logic [47:0] bq[$];
    int          bc[$];
    int done_n = 0, done_cyc = 0, err_n = 0, err_cyc = 0, rej_n = 0, rej_cyc = 0;
    logic done_busy, err_busy, busy_t;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (in_valid) begin
            bq.push_back({x_real, delta_real, delta_img});
            bc.push_back(cyc);
        end
        if (frame_done) begin done_n++; done_cyc = cyc; done_busy = busy; end
        if (frame_err)  begin err_n++;  err_cyc  = cyc; err_busy  = busy; end
        if (wr_reject)  begin rej_n++;  rej_cyc  = cyc; end
        if (cyc == t) busy_t = busy;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic write_all(input bit pat);
        int r0 = rej_n;
        for (int k = 0; k < N; k++) begin
            @(negedge clk);
            wr_en   = 1'b1;
            wr_addr = 8'(k);
            if (pat) begin
                wr_x  = 16'(k);
                wr_dr = 16'(32'h4000 - k);
                wr_di = 16'(k << 4);
            end else begin
                wr_x  = 16'($urandom);
                wr_dr = 16'($urandom);
                wr_di = 16'($urandom);
            end
            mx[k] = wr_x; mdr[k] = wr_dr; mdi[k] = wr_di;
        end
        @(negedge clk);
        wr_en = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_write_reject", 64'(rej_n - r0), 0);
    endtask

    task automatic run_frame(input string tag, input int nret, input int ret_start,
                             input bit gaps, input bit wr_start, input bit inj_wr,
                             input bit inj_start);
        int b0, d0, e0, r0, sent, last_edge, post, r, nb;
        b0 = bq.size(); d0 = done_n; e0 = err_n; r0 = rej_n;
        sent = 0; last_edge = -1; post = 0;
        @(negedge clk);
        start = 1'b1;
        if (wr_start) begin
            wr_en = 1'b1; wr_addr = 8'd5; wr_x = 16'h7FFF; wr_dr = 16'h7FFF; wr_di = 16'h7FFF;
        end
        t = cyc + 1;
        for (int c = 0; c < N + WAIT_MAX + 400 && post < 8; c++) begin
            @(negedge clk);
            start = 1'b0; wr_en = 1'b0; out_valid = 1'b0;
            r = cyc + 1 - t;
            if (sent < nret && r >= ret_start && (!gaps || $urandom_range(0, 3) != 0)) begin
                out_valid = 1'b1; sent++; last_edge = cyc + 1;
            end
            if (inj_start && (r == 100 || r == 270)) start = 1'b1;
            if (inj_wr && r == 50) begin
                wr_en = 1'b1; wr_addr = 8'd5; wr_x = 16'h7FFF; wr_dr = 16'h7FFF; wr_di = 16'h7FFF;
            end
            if (done_n != d0 || err_n != e0) post++;
        end
        start = 1'b0; wr_en = 1'b0; out_valid = 1'b0;

        nb = bq.size() - b0;
        chk({tag, "_beats"}, 64'(nb), 64'(N));
        chk({tag, "_busy_t"}, 64'(busy_t), 1);
        for (int k = 0; k < N && k < nb; k++) begin
            chk({tag, "_data"}, 64'(bq[b0+k]), 64'({mx[k], mdr[k], mdi[k]}));
            chk({tag, "_beat_cyc"}, 64'(bc[b0+k]), 64'(t + k));
        end
        if (nret == N) begin
            chk({tag, "_done_n"}, 64'(done_n - d0), 1);
            chk({tag, "_done_cyc"}, 64'(done_cyc), 64'(last_edge));
            chk({tag, "_done_busy"}, 64'(done_busy), 0);
            chk({tag, "_err_n"}, 64'(err_n - e0), 0);
        end else begin
            chk({tag, "_err_n"}, 64'(err_n - e0), 1);
            chk({tag, "_err_cyc"}, 64'(err_cyc), 64'(t + N + WAIT_MAX));
            chk({tag, "_err_busy"}, 64'(err_busy), 0);
            chk({tag, "_done_n"}, 64'(done_n - d0), 0);
        end
        chk({tag, "_rej_n"}, 64'(rej_n - r0), 64'(int'(wr_start) + int'(inj_wr)));
        if (wr_start || inj_wr)
            chk({tag, "_rej_cyc"}, 64'(rej_cyc), 64'(inj_wr ? t + 50 : t));
    endtask

    task automatic reset_mid_send();
        int b0 = bq.size();
        @(negedge clk);
        start = 1'b1;
        t = cyc + 1;
        @(negedge clk);
        start = 1'b0;
        repeat (128) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_beats_before", 64'(bq.size() - b0), 129);
        chk("arst_in_valid", 64'(in_valid), 0);
        chk("arst_data", 64'({x_real, delta_real, delta_img}), 0);
        chk("arst_busy", 64'(busy), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("arst_release_busy", 64'(busy), 0);
        chk("arst_release_valid", 64'(in_valid), 0);
    endtask

    initial begin
        rst_n = 1'b0; wr_en = 1'b0; start = 1'b0; out_valid = 1'b0;
        wr_addr = '0; wr_x = '0; wr_dr = '0; wr_di = '0;
        repeat (3) @(negedge clk);
        chk("rst_in_valid", 64'(in_valid), 0);
        chk("rst_data", 64'({x_real, delta_real, delta_img}), 0);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_pulses", 64'({frame_done, frame_err, wr_reject}), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        write_all(1'b1);
        run_frame("basic", N, 300, 1'b0, 1'b0, 1'b0, 1'b0);

        write_all(1'b0);
        run_frame("timeout_wrsend", N - 1, 300, 1'b1, 1'b0, 1'b1, 1'b0);
        run_frame("resend_wrstart_ignstart", N, 300, 1'b1, 1'b1, 1'b0, 1'b1);
        run_frame("after_wrstart", N, 280, 1'b1, 1'b0, 1'b0, 1'b0);

        reset_mid_send();
        run_frame("after_arst", N, 290, 1'b1, 1'b0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/mc_frame_tx.md
# mc_frame_tx

Frame transmitter for the Monte-Carlo FFT→MULT→IFFT datapath (`MC`). It holds one 256-sample frame loaded over a simple host write port. On `start` it streams the frame into `MC` as 256 back-to-back `in_valid` beats carrying `x_real`, `delta_real` and `delta_img`. It then counts the 256 returning `out_valid` beats and reports completion or timeout, so only one frame is in flight in `MC` at a time.

## Interface
- `N`, 256: samples per frame; power of two.
- `DW`, 16: sample width (signed Q1.15).
- `WAIT_MAX`, 4096: cycles allowed in WAIT_RES before timeout.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: one clock; reset is asynchronous and active-low.
- `wr_en` in 1: host write strobe.
- `wr_addr` in log2(N): sample index.
- `wr_x` in DW: x_real value for the index.
- `wr_dr` in DW: delta_real value for the index.
- `wr_di` in DW: delta_img value for the index.
- `start` in 1: single-cycle request to send the frame.
- `wr_reject` out 1: one-cycle pulse; write dropped.
- `busy` out 1: high in any state other than IDLE.
- `in_valid` out 1: drives `MC.in_valid`.
- `x_real` out DW: drives `MC.x_real`.
- `delta_real` out DW: drives `MC.delta_real`.
- `delta_img` out DW: drives `MC.delta_img`.
- `out_valid` in 1: return strobe from `MC`.
- `frame_done` out 1: one-cycle pulse when N results are received.
- `frame_err` out 1: one-cycle pulse on timeout.

## Operation
- Buffer: three N×DW register arrays. The buffer is not reset; contents are unknown until written.
- Writes: when `wr_en` is high and the state is IDLE, the write is stored at the edge.
  - A write in any other state is dropped and `wr_reject` pulses.
  - A write in IDLE at the same edge as `start` is dropped and `wr_reject` pulses, so the frame sent is always a stable snapshot.
- FSM has three states: IDLE, SEND and WAIT_RES.
- IDLE → SEND on `start`.
  - At that edge the output registers load index 0, `in_valid` is set to 1, and both `tx_cnt` and `rx_cnt` are cleared.
  - `start` is ignored outside IDLE.
- SEND: each edge loads index `tx_cnt`+1. After index N−1 has been presented, the next edge clears `in_valid`, zeroes the data outputs and moves to WAIT_RES.
- `rx_cnt` counts `out_valid` beats in both SEND and WAIT_RES. `out_valid` in IDLE is ignored.
- WAIT_RES:
  - When `rx_cnt` reaches N, `frame_done` pulses for one cycle and the state returns to IDLE. If N is reached during SEND, the pulse fires on the first WAIT_RES cycle.
  - `wait_cnt` increments every WAIT_RES cycle. When it reaches `WAIT_MAX`, `frame_err` pulses and the state returns to IDLE; `frame_done` does not fire.
- Counters: `tx_cnt` and `rx_cnt` are log2(N)+1 bits wide, so there is no wrap ambiguity at N. `wait_cnt` is wide enough to hold `WAIT_MAX`.
- Data is passed through unmodified; there is no arithmetic on samples.

## Timing
- Reset (async assert, sync release) sets state IDLE and drives all outputs to 0: `in_valid`, `x_real`, `delta_real`, `delta_img`, `busy`, `frame_done`, `frame_err`, `wr_reject`.
- Reset mid-SEND stops `in_valid` immediately (async). The downstream `MC` shares `rst_n`, so its partial frame is discarded as well.
- `start` sampled at edge t:
  - `in_valid` is high for edges t+1 … t+N inclusive, carrying samples 0…N−1 with no gaps.
  - `in_valid` is 0 at t+N+1.
  - `busy` is high from t+1.
- `frame_done`/`frame_err` are registered. `busy` drops in the same cycle as the pulse, and a new `start` is accepted on that cycle's edge.
- `wr_reject` is registered and pulses one cycle after the rejected write.
- All outputs are registered; there are no combinational input→output paths.

## Structure
- Shared package `mc_pkg` holds:
  - `MC_N = 256` and `MC_DW = 16`;
  - the state enum `mc_tx_state_t {IDLE, SEND, WAIT_RES}`;
  - `MC_WAIT_MAX`.
- One sub-module, `mc_frame_buf`: three-lane register file with one write port and one read port (index → registered data).

## Test plan
- Basic stream: write `wr_x`=k, `wr_dr`=0x4000−k, `wr_di`=k<<4 for k = 0…255, then pulse `start` at edge t.
  - `in_valid` is high for exactly 256 edges t+1…t+256.
  - The beat at t+1+k carries (k, 0x4000−k, k<<4).
  - `busy` is 1 from t+1.
- Completion: after the basic stream, drive 256 `out_valid` beats starting 300 cycles after `start`.
  - `frame_done` pulses once, on the cycle after the 256th beat; `busy` drops in that same cycle.
  - `frame_err` stays 0.
- Timeout: send a frame and return only 255 `out_valid` beats.
  - `frame_err` pulses exactly `WAIT_MAX` cycles after WAIT_RES entry; `frame_done` never pulses.
  - A following `start` streams the frame again.
- Rejected writes: `wr_en` during SEND with addr 5 and value 0x7FFF.
  - `wr_reject` pulses and sample 5 of the next frame keeps its old value.
  - `wr_en` together with `start` in IDLE gives the same result.
- Ignored `start`: pulse `start` at SEND beat 100 and again in WAIT_RES.
  - The stream is unchanged, the total is 256 beats, and no second frame is sent.
- Async reset: assert `rst_n`=0 at SEND beat 128, between clock edges.
  - `in_valid` and the data outputs go to 0 before the next edge.
  - After release the state is IDLE, and `start` produces a full 256-beat frame from index 0.
